// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush/forwarding control and external-interrupt FSM for the 5-stage MIPS pipeline.
module hazard_ctrl #(
  parameter bit EN_PERF = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_use_rt,
  input  logic        id_valid,
  input  logic        id_jump,
  input  logic        id_eret,
  input  logic [31:0] id_pc_plus_4,
  input  logic        ex_regwrite,
  input  logic        ex_memread,
  input  logic [4:0]  ex_wr,
  input  logic        mem_regwrite,
  input  logic [4:0]  mem_wr,
  input  logic        ex_branch_taken,
  input  logic        irq,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        if_flush,
  output logic        ex_flush,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
  output logic        int_take,
  output logic [31:0] epc,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);
  typedef enum logic [1:0] {IDLE, PEND, SERVICE} state_t;
  state_t state;
  logic lu, stall, take, jmp;
  logic [1:0] fa, fb;
  always_comb begin
    lu = id_valid & ex_memread & (ex_wr != 5'd0) & ((ex_wr == id_rs) | (id_use_rt & (ex_wr == id_rt)));
    stall = !ex_branch_taken & lu;
    take = !ex_branch_taken & !lu & (state == PEND) & id_valid & !id_eret;
    jmp = !ex_branch_taken & !lu & !take & id_jump;
    // Combinational controls are held at their idle values while reset is asserted.
    pc_write = !reset | !stall;
    ifid_write = !reset | !stall;
    if_flush = reset & (ex_branch_taken | take | jmp);
    ex_flush = reset & (ex_branch_taken | stall | take);
    int_take = reset & take;
    fa = (ex_regwrite && ex_wr != 5'd0 && ex_wr == id_rs) ? 2'b10 :
         (mem_regwrite && mem_wr != 5'd0 && mem_wr == id_rs) ? 2'b01 : 2'b00;
    fb = !id_use_rt ? 2'b00 :
         (ex_regwrite && ex_wr != 5'd0 && ex_wr == id_rt) ? 2'b10 :
         (mem_regwrite && mem_wr != 5'd0 && mem_wr == id_rt) ? 2'b01 : 2'b00;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      epc <= 32'd0;
      fwd_a <= 2'b00;
      fwd_b <= 2'b00;
    end else begin
      fwd_a <= ex_flush ? 2'b00 : fa;
      fwd_b <= ex_flush ? 2'b00 : fb;
      if (take) epc <= id_pc_plus_4 - 32'd4;
      state <= (state == IDLE && irq) ? PEND :
               take ? SERVICE :
               (state == SERVICE && id_eret && !ex_branch_taken) ? IDLE : state;
    end
  end
  if (EN_PERF) begin : g_perf
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        stall_cnt <= 16'd0;
        flush_cnt <= 16'd0;
      end else begin
        if (stall && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
        if (if_flush && flush_cnt != 16'hFFFF) flush_cnt <= flush_cnt + 16'd1;
      end
    end
  end else begin : g_noperf
    assign stall_cnt = 16'd0;
    assign flush_cnt = 16'd0;
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed-vector bench for hazard_ctrl with hand-computed expectations.
module tb_hazard_ctrl;
  logic clk = 1'b0, reset = 1'b0;
  logic [4:0] id_rs, id_rt, ex_wr, mem_wr;
  logic id_use_rt, id_valid, id_jump, id_eret, ex_regwrite, ex_memread, mem_regwrite, ex_branch_taken, irq;
  logic [31:0] id_pc_plus_4, epc;
  logic pc_write, ifid_write, if_flush, ex_flush, int_take;
  logic [1:0] fwd_a, fwd_b;
  logic [15:0] stall_cnt, flush_cnt;
  int tests = 0, errs = 0;
  always #5 clk = ~clk;
  hazard_ctrl #(.EN_PERF(1'b1)) dut (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_use_rt(id_use_rt),
    .id_valid(id_valid), .id_jump(id_jump), .id_eret(id_eret), .id_pc_plus_4(id_pc_plus_4),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_wr(ex_wr),
    .mem_regwrite(mem_regwrite), .mem_wr(mem_wr), .ex_branch_taken(ex_branch_taken), .irq(irq),
    .pc_write(pc_write), .ifid_write(ifid_write), .if_flush(if_flush), .ex_flush(ex_flush),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .int_take(int_take), .epc(epc),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic clr();
    id_rs = 0; id_rt = 0; ex_wr = 0; mem_wr = 0; id_use_rt = 0; id_valid = 0; id_jump = 0;
    id_eret = 0; ex_regwrite = 0; ex_memread = 0; mem_regwrite = 0; ex_branch_taken = 0;
    irq = 0; id_pc_plus_4 = 0;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    clr();
    #2;
    check("rst_pc_write", pc_write, 1);
    check("rst_ifid_write", ifid_write, 1);
    check("rst_if_flush", if_flush, 0);
    check("rst_ex_flush", ex_flush, 0);
    check("rst_int_take", int_take, 0);
    check("rst_fwd_a", fwd_a, 0);
    check("rst_epc", epc, 0);
    check("rst_stall_cnt", stall_cnt, 0);
    @(negedge clk);
    reset = 1'b1;
    tick();
    // load-use: lw $8 in EX, consumer of $8 in ID
    id_valid = 1; id_rs = 8; ex_memread = 1; ex_regwrite = 1; ex_wr = 8;
    #1;
    check("lu_pc_write", pc_write, 0);
    check("lu_ifid_write", ifid_write, 0);
    check("lu_ex_flush", ex_flush, 1);
    check("lu_if_flush", if_flush, 0);
    tick();
    check("lu_stall_cnt", stall_cnt, 1);
    check("lu_fwd_a_bubble", fwd_a, 0);
    ex_memread = 0; ex_regwrite = 0; ex_wr = 0; mem_regwrite = 1; mem_wr = 8;
    #1;
    check("lu_once_pc_write", pc_write, 1);
    tick();
    check("lu_fwd_a_mem", fwd_a, 2'b01);
    check("lu_stall_cnt_hold", stall_cnt, 1);
    // EX forwarding and the $0 exclusion
    clr(); id_valid = 1; ex_regwrite = 1; ex_wr = 5; id_rs = 5; id_rt = 5; id_use_rt = 1;
    tick();
    check("fwd_ex_a", fwd_a, 2'b10);
    check("fwd_ex_b", fwd_b, 2'b10);
    ex_wr = 0;
    tick();
    check("fwd_r0_a", fwd_a, 0);
    check("fwd_r0_b", fwd_b, 0);
    ex_wr = 5; id_use_rt = 0;
    tick();
    check("fwd_nort_a", fwd_a, 2'b10);
    check("fwd_nort_b", fwd_b, 0);
    // branch beats load-use and a pending interrupt
    clr(); irq = 1;
    tick();
    irq = 0;
    #1;
    check("pend_noid_take", int_take, 0);
    tick();
    ex_branch_taken = 1; ex_memread = 1; ex_wr = 8; id_rs = 8; id_valid = 1;
    #1;
    check("br_if_flush", if_flush, 1);
    check("br_ex_flush", ex_flush, 1);
    check("br_pc_write", pc_write, 1);
    check("br_int_take", int_take, 0);
    tick();
    check("br_stall_cnt", stall_cnt, 1);
    clr(); id_valid = 1; id_pc_plus_4 = 32'h00400100;
    #1;
    check("br_then_take", int_take, 1);
    check("take_ex_flush", ex_flush, 1);
    tick();
    check("br_then_epc", epc, 32'h004000FC);
    id_eret = 1;
    #1;
    check("svc_eret_take", int_take, 0);
    tick();
    // one-cycle irq pulse, masking in SERVICE, ERET and retake
    clr(); id_valid = 1; id_pc_plus_4 = 32'h00400010; irq = 1;
    #1;
    check("irq_idle_take", int_take, 0);
    tick();
    irq = 0;
    #1;
    check("irq_take", int_take, 1);
    tick();
    check("irq_epc", epc, 32'h0040000C);
    check("irq_take_pulse", int_take, 0);
    irq = 1;
    repeat (3) tick();
    check("svc_masked", int_take, 0);
    id_eret = 1;
    #1;
    check("eret_no_take", int_take, 0);
    tick();
    id_eret = 0;
    #1;
    check("post_eret_idle", int_take, 0);
    tick();
    check("retake", int_take, 1);
    tick();
    check("flush_cnt_4", flush_cnt, 4);
    irq = 0; id_eret = 1;
    tick();
    // jump and flush counter saturation
    clr(); id_jump = 1;
    #1;
    check("jmp_if_flush", if_flush, 1);
    check("jmp_ex_flush", ex_flush, 0);
    check("jmp_pc_write", pc_write, 1);
    tick();
    check("jmp_flush_cnt", flush_cnt, 5);
    repeat (65535) tick();
    check("flush_cnt_sat", flush_cnt, 16'hFFFF);
    tick();
    check("flush_cnt_sat_hold", flush_cnt, 16'hFFFF);
    // asynchronous reset in SERVICE
    clr(); id_valid = 1; irq = 1;
    tick();
    irq = 0;
    tick();
    ex_regwrite = 1; ex_wr = 5; id_rs = 5;
    tick();
    check("svc_fwd_a", fwd_a, 2'b10);
    ex_memread = 1;
    #1;
    check("svc_lu_pc_write", pc_write, 0);
    reset = 1'b0;
    #1;
    check("arst_pc_write", pc_write, 1);
    check("arst_ifid_write", ifid_write, 1);
    check("arst_ex_flush", ex_flush, 0);
    check("arst_fwd_a", fwd_a, 0);
    check("arst_epc", epc, 0);
    check("arst_flush_cnt", flush_cnt, 0);
    check("arst_stall_cnt", stall_cnt, 0);
    reset = 1'b1;
    clr(); id_valid = 1; irq = 1;
    tick();
    irq = 0;
    #1;
    check("arst_idle_retake", int_take, 1);
    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end
endmodule
